ca_egr_snd_protocol_error_collector: RTL and testbench

CA_EGR_SND_PROTOCOL_ERROR_COLLECTOR -- requirements
Module: ca_egr_snd_protocol_error_collector

---
 rtl/ca_egr_snd_pkg.sv | 39 +++
 rtl/ca_egr_snd_sat_counter.sv | 37 +++
 rtl/ca_egr_snd_protocol_error_collector.sv | 155 +++++++++++++++
 tb/tb_ca_egr_snd_protocol_error_collector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ca_egr_snd_pkg.sv
// ---------------------------------------------------------------------------
// ca_egr_snd_pkg
// Shared definitions for the egress-send protocol error collector:
//   - bit positions of the faults in the 16-bit protocol monitor vector
//   - RSVD_MASK, which removes the reserved positions (10, 11, 14, 15)
//   - FSM state enumeration for the collector
//   - effective_faults(): applies the software mask and the reserved mask
// ---------------------------------------------------------------------------
package ca_egr_snd_pkg;

  // Fault bit positions reported by the egress-send protocol monitor.
  localparam int unsigned ERR_CHAN_EQ        = 0;
  localparam int unsigned ERR_ADDR_ALIGN     = 1;
  localparam int unsigned ERR_LEN_NONZERO    = 2;
  localparam int unsigned ERR_LEN_MAX        = 3;
  localparam int unsigned ERR_BURST_TYPE     = 4;
  localparam int unsigned ERR_SIZE_EQ        = 5;
  localparam int unsigned ERR_ID_EQ          = 6;
  localparam int unsigned ERR_LAST_ALIGN     = 7;
  localparam int unsigned ERR_STRB_VALID     = 8;
  localparam int unsigned ERR_RESP_ORDER     = 9;
  localparam int unsigned ERR_RESP_OKAY      = 12;
  localparam int unsigned ERR_RESP_BL_EQ_REQ = 13;

  // Positions 10, 11, 14 and 15 are reserved and never reported.
  localparam logic [15:0] RSVD_MASK = 16'h33FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ERR  = 1'b1
  } state_e;

  // Fault bits that are neither masked by software nor reserved.
  function automatic logic [15:0] effective_faults(input logic [15:0] faults,
                                                   input logic [15:0] mask);
    return faults & ~mask & RSVD_MASK;
  endfunction

endpackage

// File: rtl/ca_egr_snd_sat_counter.sv
// ---------------------------------------------------------------------------
// ca_egr_snd_sat_counter
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: load1 > clr > inc. The count sticks at all-ones.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - increment by one (saturating)
//   clr       - force count to zero
//   load1     - force count to one (clear immediately followed by one event)
//   count     - registered count value
// ---------------------------------------------------------------------------
module ca_egr_snd_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load1,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load1) begin
      count <= WIDTH'(1);
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ca_egr_snd_protocol_error_collector.sv
// ---------------------------------------------------------------------------
// ca_egr_snd_protocol_error_collector
// Collects faults from the egress-send protocol monitor: sticky OR of all
// unmasked faults, the fault vector of the first event, a saturating count
// of event cycles, the timestamp of the first event and a level interrupt.
// All outputs are registered (one cycle of latency from the sampling edge).
//
// Parameters:
//   COUNT_WIDTH            - width of err_count (8..32)
// Ports:
//   ap_clk                 - clock, rising edge
//   ap_rst                 - asynchronous active-high reset
//   protocol_error[15:0]   - fault vector from the protocol monitor
//   protocol_error_ap_vld  - qualifies protocol_error
//   err_mask[15:0]         - 1 = ignore that fault bit
//   err_clear              - pulse; clears collected state
//   err_sticky[15:0]       - OR of unmasked faults since the last clear
//   err_first[15:0]        - unmasked faults of the first event
//   err_count              - saturating number of event cycles
//   err_first_time[31:0]   - cycle timestamp of the first event
//   err_irq                - high while in the ERR state
//
// Build option: define CA_EGR_SND_ERR_TIMESTAMP_EN to include the 32-bit
// free-running cycle counter; otherwise err_first_time is tied to 0.
// ---------------------------------------------------------------------------
module ca_egr_snd_protocol_error_collector
  import ca_egr_snd_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [15:0]            protocol_error,
  input  logic                   protocol_error_ap_vld,
  input  logic [15:0]            err_mask,
  input  logic                   err_clear,
  output logic [15:0]            err_sticky,
  output logic [15:0]            err_first,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [31:0]            err_first_time,
  output logic                   err_irq
);

  state_e      state;
  state_e      state_next;
  logic [15:0] eff;
  logic        event_hit;
  logic        load_first;  // start a fresh collection with this event
  logic        accumulate;  // add this event to an existing collection
  logic        clear_only;  // clear with no event in the same cycle

  assign eff       = effective_faults(protocol_error, err_mask);
  assign event_hit = protocol_error_ap_vld && (eff != '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and datapath controls. A clear that coincides with an
  // event behaves as clear-then-event, so it reloads rather than clears.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_next = state;
    load_first = 1'b0;
    accumulate = 1'b0;
    clear_only = 1'b0;

    if (event_hit) begin
      state_next = ST_ERR;
      if (err_clear || (state == ST_IDLE)) begin
        load_first = 1'b1;
      end else begin
        accumulate = 1'b1;
      end
    end else if (err_clear) begin
      state_next = ST_IDLE;
      clear_only = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky and first-event vectors. Only eff is ever latched, so a later
  // change of err_mask cannot alter bits already collected.
  // ---------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_sticky <= '0;
      err_first  <= '0;
    end else if (load_first) begin
      err_sticky <= eff;
      err_first  <= eff;
    end else if (accumulate) begin
      err_sticky <= err_sticky | eff;
    end else if (clear_only) begin
      err_sticky <= '0;
      err_first  <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Event counter
  // ---------------------------------------------------------------------
  ca_egr_snd_sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_count (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .inc   (accumulate),
    .clr   (clear_only),
    .load1 (load_first),
    .count (err_count)
  );

  // ---------------------------------------------------------------------
  // First-event timestamp
  // ---------------------------------------------------------------------
`ifdef CA_EGR_SND_ERR_TIMESTAMP_EN
  logic [31:0] cycle_count;

  // Free-running; wraps naturally from all-ones to zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_first_time <= '0;
    end else if (load_first) begin
      err_first_time <= cycle_count;
    end else if (clear_only) begin
      err_first_time <= '0;
    end
  end
`else
  assign err_first_time = 32'd0;
`endif

  // Interrupt comes straight from the state register.
  assign err_irq = (state == ST_ERR);

endmodule

// File: tb/tb_ca_egr_snd_protocol_error_collector.sv
// ---------------------------------------------------------------------------
// tb_ca_egr_snd_protocol_error_collector
// Directed, self-checking bench. Each step drives one cycle of inputs,
// computes the expected registered outputs from a behavioural model and
// pushes them to a scoreboard; after the sampling edge the entry is popped
// and compared against the DUT. Built with COUNT_WIDTH = 8.
// ---------------------------------------------------------------------------
module tb_ca_egr_snd_protocol_error_collector;

  localparam int unsigned CW = 8;

  typedef struct {
    logic [15:0]   sticky;
    logic [15:0]   first;
    logic [CW-1:0] count;
    logic [31:0]   ftime;
    logic          irq;
  } exp_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [15:0]   protocol_error = '0;
  logic          protocol_error_ap_vld = 1'b0;
  logic [15:0]   err_mask = '0;
  logic          err_clear = 1'b0;
  logic [15:0]   err_sticky;
  logic [15:0]   err_first;
  logic [CW-1:0] err_count;
  logic [31:0]   err_first_time;
  logic          err_irq;

  int vectors     = 0;
  int miscompares = 0;

  exp_t sb[$];

  // Behavioural model state
  logic [15:0]   m_sticky = '0;
  logic [15:0]   m_first  = '0;
  logic [CW-1:0] m_count  = '0;
  logic [31:0]   m_ftime  = '0;
  logic          m_irq    = 1'b0;
  logic [31:0]   m_ts     = '0;

  ca_egr_snd_protocol_error_collector #(
    .COUNT_WIDTH (CW)
  ) dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .protocol_error        (protocol_error),
    .protocol_error_ap_vld (protocol_error_ap_vld),
    .err_mask              (err_mask),
    .err_clear             (err_clear),
    .err_sticky            (err_sticky),
    .err_first             (err_first),
    .err_count             (err_count),
    .err_first_time        (err_first_time),
    .err_irq               (err_irq)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sticky = '0;
    m_first  = '0;
    m_count  = '0;
    m_ftime  = '0;
    m_irq    = 1'b0;
    m_ts     = '0;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".sticky"}, 32'(err_sticky), 32'h0);
    cmp({tag, ".first"},  32'(err_first),  32'h0);
    cmp({tag, ".count"},  32'(err_count),  32'h0);
    cmp({tag, ".ftime"},  err_first_time,  32'h0);
    cmp({tag, ".irq"},    32'(err_irq),    32'h0);
  endtask

  // One clock cycle: called just after a rising edge; drives inputs, pushes
  // the model's prediction, waits for the next edge and checks.
  task automatic step(input string tag, input logic vld, input logic [15:0] err,
                      input logic [15:0] mask, input logic clr);
    logic [15:0] eff;
    logic        ev;
    exp_t        e;
    exp_t        got;

    protocol_error        = err;
    protocol_error_ap_vld = vld;
    err_mask              = mask;
    err_clear             = clr;

    eff = err & ~mask & 16'h33FF;
    ev  = vld && (eff != 16'h0);
    if (ev && (clr || !m_irq)) begin
      m_first  = eff;
      m_sticky = eff;
      m_count  = 1;
      m_ftime  = m_ts;
      m_irq    = 1'b1;
    end else if (ev) begin
      m_sticky = m_sticky | eff;
      if (m_count != {CW{1'b1}}) m_count = m_count + 1'b1;
    end else if (clr) begin
      m_first  = '0;
      m_sticky = '0;
      m_count  = '0;
      m_ftime  = '0;
      m_irq    = 1'b0;
    end
    m_ts = m_ts + 32'd1;

    e.sticky = m_sticky;
    e.first  = m_first;
    e.count  = m_count;
`ifdef CA_EGR_SND_ERR_TIMESTAMP_EN
    e.ftime  = m_ftime;
`else
    e.ftime  = 32'h0;
`endif
    e.irq    = m_irq;
    sb.push_back(e);

    @(posedge ap_clk);
    #1;
    got = sb.pop_front();
    cmp({tag, ".sticky"}, 32'(err_sticky), 32'(got.sticky));
    cmp({tag, ".first"},  32'(err_first),  32'(got.first));
    cmp({tag, ".count"},  32'(err_count),  32'(got.count));
    cmp({tag, ".ftime"},  err_first_time,  got.ftime);
    cmp({tag, ".irq"},    32'(err_irq),    32'(got.irq));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    // Reset state
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check_zero("reset");
    ap_rst = 1'b0;
    model_reset();

    // Single event
    step("single",      1'b1, 16'h0041, 16'h0000, 1'b0);
    idle("single_hold");
    step("clr1",        1'b0, 16'h0000, 16'h0000, 1'b1);

    // Accumulate two events; reserved-only vld is not an event
    step("acc1",        1'b1, 16'h0002, 16'h0000, 1'b0);
    step("acc2",        1'b1, 16'h1000, 16'h0000, 1'b0);
    step("rsvd_only",   1'b1, 16'hCC00, 16'h0000, 1'b0);
    step("novld",       1'b0, 16'h0008, 16'h0000, 1'b0);
    step("clr2",        1'b0, 16'h0000, 16'h0000, 1'b1);

    // Masked and reserved bits only -> no event
    step("mask_rsvd",   1'b1, 16'hC401, 16'h0001, 1'b0);
    idle("mask_idle");

    // Clear collision at count 5
    for (int i = 0; i < 5; i++) step("build5", 1'b1, 16'h0100, 16'h0000, 1'b0);
    step("clr_collide", 1'b1, 16'h0080, 16'h0000, 1'b1);
    step("clr_alone",   1'b0, 16'h0000, 16'h0000, 1'b1);
    step("clr_idle",    1'b0, 16'h0000, 16'h0000, 1'b1);
    step("idle_collide", 1'b1, 16'h2000, 16'h0000, 1'b1);

    // Mask change after latching leaves collected bits alone
    step("mask_pre",    1'b1, 16'h0004, 16'h0000, 1'b0);
    step("mask_after",  1'b0, 16'h0000, 16'h0004, 1'b0);
    step("mask_next",   1'b1, 16'h0006, 16'h0004, 1'b0);
    step("clr3",        1'b0, 16'h0000, 16'h0000, 1'b1);

    // Multi-cycle vld: counts only the cycles holding an event
    step("mc1",         1'b1, 16'h0010, 16'h0000, 1'b0);
    step("mc2",         1'b1, 16'h0000, 16'h0000, 1'b0);
    step("mc3",         1'b1, 16'h0020, 16'h0000, 1'b0);
    step("mc4",         1'b1, 16'h0020, 16'h0000, 1'b0);
    step("clr4",        1'b0, 16'h0000, 16'h0000, 1'b1);

    // Saturation over 300 consecutive event cycles, then hold
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 16'h0200, 16'h0000, 1'b0);
    step("sat_hold1",   1'b1, 16'h0001, 16'h0000, 1'b0);
    idle("sat_hold2");

    // Asynchronous reset mid-operation, between clock edges
    #2;
    ap_rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    model_reset();

    // Timestamp: first event 100 cycles after release, then a later event
    for (int i = 0; i < 100; i++) idle("ts_idle");
    step("ts_first",    1'b1, 16'h0040, 16'h0000, 1'b0);
    idle("ts_gap");
    step("ts_later",    1'b1, 16'h0800, 16'h0000, 1'b0);
    step("ts_clr",      1'b0, 16'h0000, 16'h0000, 1'b1);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
